mmcm_reconfig_ctrl: RTL and testbench

Sequencer that reprograms the clock-generation MMCM through its Dynamic Reconfiguration Port (DRP) on request. It runs on a free-running clock that is not derived from the MMCM: it holds the MMCM in reset, performs a read-modify-write on a list of DRP registers, releases reset, and waits for lock. It sits beside the clock wizard instance in the clock generator and is driven by the host/debug control logic.

---
 rtl/mmcm_reconfig_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mmcm_reconfig_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reconfig_ctrl.sv
// MMCM DRP reconfiguration sequencer: holds the MMCM in reset, read-modify-writes N_REGS DRP
// registers, releases reset and waits for lock. Optional lock timeout: MMCM_RECONFIG_TIMEOUT_EN.
module mmcm_reconfig_ctrl #(
    parameter int N_REGS       = 2,
    parameter int RST_HOLD     = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [7*N_REGS-1:0]  cfg_addr,
    input  logic [16*N_REGS-1:0] cfg_mask,
    input  logic [16*N_REGS-1:0] cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mmcm_rst,
    input  logic                 locked,
    output logic [6:0]           daddr,
    output logic [15:0]          di,
    input  logic [15:0]          dout,
    output logic                 den,
    output logic                 dwe,
    input  logic                 drdy,
    output logic [2:0]           dbg_state
);
    localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RELEASE, S_LOCK_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [7*N_REGS-1:0]  addr_q, addr_d;
    logic [16*N_REGS-1:0] mask_q, mask_d;
    logic [16*N_REGS-1:0] data_q, data_d;
    logic [15:0]          rd_q, rd_d;
    logic                 done_q, done_d;
    logic                 lock_s1_q, lock_s2_q;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
    logic [31:0]          tmo_cnt_q, tmo_cnt_d;
    logic                 err_q, err_d;
`endif

    logic [6:0]  cur_addr;
    logic [15:0] cur_mask;
    logic [15:0] cur_data;

    assign cur_addr  = addr_q[7*int'(idx_q) +: 7];
    assign cur_mask  = mask_q[16*int'(idx_q) +: 16];
    assign cur_data  = data_q[16*int'(idx_q) +: 16];
    assign dbg_state = state_q;

    // DRP handshake: den (with dwe for writes) is a single-cycle request; the access is
    // complete when drdy is sampled high in the matching wait state. drdy elsewhere is ignored.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        data_d     = data_q;
        rd_d       = rd_q;
        done_d     = 1'b0;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = cfg_addr;
                    mask_d     = cfg_mask;
                    data_d     = cfg_data;
                    idx_d      = '0;
                    hold_cnt_d = '0;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = S_RD;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drdy) begin
                    rd_d    = dout;
                    state_d = S_WR;
                end
            end
            S_WR: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drdy) begin
                    if (idx_q == IDX_W'(N_REGS - 1)) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_RELEASE: begin
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                // A lock seen on the final timeout cycle still counts as success.
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                else if (tmo_cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        mmcm_rst = 1'b0;
        den      = 1'b0;
        dwe      = 1'b0;
        daddr    = 7'h00;
        di       = 16'h0000;
        case (state_q)
            S_HOLD, S_RD_WAIT, S_WR_WAIT: mmcm_rst = 1'b1;
            S_RD: begin
                mmcm_rst = 1'b1;
                den      = 1'b1;
                daddr    = cur_addr;
            end
            S_WR: begin
                mmcm_rst = 1'b1;
                den      = 1'b1;
                dwe      = 1'b1;
                daddr    = cur_addr;
                di       = (rd_q & ~cur_mask) | (cur_data & cur_mask);
            end
            default: ;
        endcase
    end

    assign done = done_q;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            done_q     <= 1'b0;
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            done_q     <= done_d;
            lock_s1_q  <= locked;
            lock_s2_q  <= lock_s1_q;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Self-checking bench for mmcm_reconfig_ctrl: DRP register-file model with programmable
// drdy latency, MMCM lock model, and a read-modify-write scoreboard.
module tb_mmcm_reconfig_ctrl;
    localparam int N_REGS       = 2;
    localparam int RST_HOLD     = 4;
    localparam int LOCK_TIMEOUT = 50;

    logic                 clk = 1'b0;
    logic                 rst, req, locked, drdy;
    logic [7*N_REGS-1:0]  cfg_addr;
    logic [16*N_REGS-1:0] cfg_mask, cfg_data;
    logic [15:0]          dout, di;
    logic [6:0]           daddr;
    logic                 busy, done, err, mmcm_rst, den, dwe;
    logic [2:0]           dbg_state;

    mmcm_reconfig_ctrl #(.N_REGS(N_REGS), .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
        .cfg_data(cfg_data), .busy(busy), .done(done), .err(err), .mmcm_rst(mmcm_rst),
        .locked(locked), .daddr(daddr), .di(di), .dout(dout), .den(den), .dwe(dwe),
        .drdy(drdy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // stimulus configuration and environment state
    logic [6:0]  t_addr [N_REGS];
    logic [15:0] t_mask [N_REGS];
    logic [15:0] t_data [N_REGS];
    logic [15:0] mem [128];
    int  k_lat = 2;
    int  lock_delay = 0;
    bit  spur_en = 1'b0;
    bit  pend = 1'b0;
    int  due = 0;
    logic [15:0] pend_val = 16'h0;
    int  since = 0;
    bit  busy_prev = 1'b0, rst_prev = 1'b0, err_prev = 1'b0;
    int  acc_cyc = 0;
    int  rst_fall_cyc = 0;

    // scoreboard and event logs
    logic [22:0] exp_q [$];
    logic [22:0] act_q [$];
    logic [6:0]  rd_addr_q [$];
    int rd_cyc_q [$], wr_cyc_q [$], done_cyc_q [$], busy_rise_q [$], err_cyc_q [$];
    int busy_at_done = 0, den_no_rst = 0, dwe_alone = 0, done_err = 0;

    // DRP register file, drdy responder and lock model, all evaluated mid-cycle
    always @(negedge clk) begin
        drdy = 1'b0;
        dout = 16'($urandom);
        if (pend && cyc == due) begin
            drdy = 1'b1;
            dout = pend_val;
            pend = 1'b0;
        end else if (spur_en && den === 1'b1) begin
            drdy = 1'b1;
            dout = 16'hDEAD;
        end
        if (den === 1'b1) begin
            if (mmcm_rst !== 1'b1) den_no_rst++;
            if (dwe === 1'b1) begin
                act_q.push_back({daddr, di});
                wr_cyc_q.push_back(cyc);
                mem[daddr] = di;
                pend_val = 16'h0;
            end else begin
                rd_addr_q.push_back(daddr);
                rd_cyc_q.push_back(cyc);
                pend_val = mem[daddr];
            end
            pend = 1'b1;
            due  = cyc + k_lat;
        end
        if (dwe === 1'b1 && den !== 1'b1) dwe_alone++;
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            if (busy !== 1'b0) busy_at_done++;
            if (err !== 1'b0) done_err++;
        end
        if (err === 1'b1 && !err_prev) err_cyc_q.push_back(cyc);
        if (busy === 1'b1 && !busy_prev) busy_rise_q.push_back(cyc);
        if (mmcm_rst === 1'b1) begin
            since  = 0;
            locked = 1'b0;
        end else begin
            if (rst_prev) begin
                since = 0;
                rst_fall_cyc = cyc;
            end else begin
                since++;
            end
            locked = (lock_delay >= 0) && (since >= lock_delay);
        end
        busy_prev = (busy === 1'b1);
        rst_prev  = (mmcm_rst === 1'b1);
        err_prev  = (err === 1'b1);
    end

    // driver tasks
    task automatic pack_cfg();
        for (int i = 0; i < N_REGS; i++) begin
            cfg_addr[7*i +: 7]   = t_addr[i];
            cfg_mask[16*i +: 16] = t_mask[i];
            cfg_data[16*i +: 16] = t_data[i];
        end
    endtask

    task automatic directed_cfg();
        t_addr[0] = 7'h08; t_mask[0] = 16'h003F; t_data[0] = 16'h0005;
        t_addr[1] = 7'h09; t_mask[1] = 16'h0FC0; t_data[1] = 16'h0140;
        mem[8'h08] = 16'hFFFF;
        mem[8'h09] = 16'h1234;
        pack_cfg();
    endtask

    // reference model: sequential read-modify-write over a copy of the register file
    task automatic build_expect(input int nseq);
        logic [15:0] mm [128];
        logic [15:0] v;
        mm = mem;
        exp_q.delete();
        for (int s = 0; s < nseq; s++) begin
            for (int i = 0; i < N_REGS; i++) begin
                v = (mm[t_addr[i]] & ~t_mask[i]) | (t_data[i] & t_mask[i]);
                exp_q.push_back({t_addr[i], v});
                mm[t_addr[i]] = v;
            end
        end
    endtask

    task automatic clear_logs();
        act_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); busy_rise_q.delete(); err_cyc_q.delete();
        busy_at_done = 0;
    endtask

    task automatic start_req();
        @(posedge clk); #1;
        req = 1'b1;
        acc_cyc = cyc;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && done_cyc_q.size() < n; i++) @(posedge clk);
        ok = (done_cyc_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, mmcm_rst, den, dwe, daddr, di} !== 29'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {busy, done, err, mmcm_rst, den, dwe, daddr, di});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mmcm_rst, den, dwe, daddr, di} !== 29'h0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", {busy, done, err, mmcm_rst, den, dwe, daddr, di});
        end
    endtask

    // one full sequence with timing checks; cfg and mem already set up
    task automatic test_sequence(input string name, input int k, input int lockd);
        bit ok;
        int base;
        k_lat = k;
        lock_delay = lockd;
        build_expect(1);
        clear_logs();
        start_req();
        wait_dones(1, 3000, ok);
        repeat (5) @(posedge clk);
        checks++;
        if (!ok || done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cyc_q.size());
        end
        checks++;
        if (busy_rise_q.size() != 1 || busy_rise_q[0] != acc_cyc + 1) begin
            errors++;
            $display("FAIL %s busy_rise: got %0d want %0d", name, busy_rise_q.size() ? busy_rise_q[0] : -1, acc_cyc + 1);
        end
        checks++;
        if (act_q.size() != exp_q.size() || rd_cyc_q.size() != N_REGS) begin
            errors++;
            $display("FAIL %s access_count: got wr=%0d rd=%0d want %0d", name, act_q.size(), rd_cyc_q.size(), N_REGS);
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                base = acc_cyc + 1 + RST_HOLD + i * 2 * (k + 1);
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write%0d: got addr=%h data=%h want addr=%h data=%h", name, i,
                             act_q[i][22:16], act_q[i][15:0], exp_q[i][22:16], exp_q[i][15:0]);
                end
                checks++;
                if (rd_addr_q[i] !== t_addr[i] || rd_cyc_q[i] != base || wr_cyc_q[i] != base + k + 1) begin
                    errors++;
                    $display("FAIL %s access%0d: got rdaddr=%h rdcyc=%0d wrcyc=%0d want %h %0d %0d", name, i,
                             rd_addr_q[i], rd_cyc_q[i], wr_cyc_q[i], t_addr[i], base, base + k + 1);
                end
            end
            checks++;
            if (rst_fall_cyc != wr_cyc_q[N_REGS-1] + k + 1) begin
                errors++;
                $display("FAIL %s mmcm_rst_fall: got %0d want %0d", name, rst_fall_cyc, wr_cyc_q[N_REGS-1] + k + 1);
            end
        end
        checks++;
        if (done_cyc_q.size() < 1 || done_cyc_q[0] != rst_fall_cyc + lockd + 3) begin
            errors++;
            $display("FAIL %s done_time: got %0d want %0d", name, done_cyc_q.size() ? done_cyc_q[0] : -1, rst_fall_cyc + lockd + 3);
        end
        checks++;
        if (busy_at_done != 0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_err_after: got busy_at_done=%0d busy=%b err=%b want 0 0 0", name, busy_at_done, busy, err);
        end
    endtask

    task automatic test_directed();
        directed_cfg();
        test_sequence("directed", 2, 0);
        directed_cfg();
        test_sequence("lock100", 2, 100);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < N_REGS; i++) begin
                t_addr[i] = 7'($urandom_range(0, 127));
                t_mask[i] = 16'($urandom);
                t_data[i] = 16'($urandom);
            end
            pack_cfg();
            test_sequence("random", $urandom_range(1, 4), $urandom_range(0, 30));
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        directed_cfg();
        k_lat = 2;
        lock_delay = 3;
        clear_logs();
        start_req();
        for (int i = 0; i < 200 && act_q.size() < 1; i++) @(posedge clk);
        checks++;
        if (act_q.size() < 1) begin
            errors++;
            $display("FAIL rst_mid_reach_wr: got %0d writes want 1", act_q.size());
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, mmcm_rst, den, dwe, daddr, di} !== 29'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h want 0", {busy, done, err, mmcm_rst, den, dwe, daddr, di});
        end
        repeat (5) @(posedge clk);
        build_expect(1);
        clear_logs();
        start_req();
        wait_dones(1, 500, ok);
        repeat (3) @(posedge clk);
        checks++;
        if (!ok || rd_addr_q.size() < 1 || rd_addr_q[0] !== 7'h08) begin
            errors++;
            $display("FAIL rst_mid_restart: got done=%0d first_rd=%h want 1 08", ok, rd_addr_q.size() ? rd_addr_q[0] : 7'h7F);
        end
        checks++;
        if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL rst_mid_writes: got n=%0d %h %h want %h %h", act_q.size(), act_q[0], act_q[1], exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_spurious();
        bit ok;
        directed_cfg();
        k_lat = 2;
        lock_delay = 2;
        spur_en = 1'b1;
        build_expect(1);
        clear_logs();
        start_req();
        cfg_addr = 14'($urandom);
        cfg_mask = 32'($urandom);
        cfg_data = 32'($urandom);
        for (int i = 0; i < 100 && rd_addr_q.size() < 1; i++) @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        wait_dones(1, 500, ok);
        repeat (30) @(posedge clk);
        spur_en = 1'b0;
        checks++;
        if (!ok || done_cyc_q.size() != 1 || busy_rise_q.size() != 1) begin
            errors++;
            $display("FAIL spurious_seq_count: got done=%0d busy_rises=%0d want 1 1", done_cyc_q.size(), busy_rise_q.size());
        end
        checks++;
        if (rd_addr_q.size() + act_q.size() != 4) begin
            errors++;
            $display("FAIL spurious_den_count: got %0d want 4", rd_addr_q.size() + act_q.size());
        end
        checks++;
        if (act_q.size() != 2 || act_q[0] !== {7'h08, 16'hFFC5} || act_q[1] !== {7'h09, 16'h1174}) begin
            errors++;
            $display("FAIL spurious_writes: got n=%0d %h %h want %h %h", act_q.size(), act_q[0], act_q[1], exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        directed_cfg();
        k_lat = 1;
        lock_delay = 5;
        build_expect(2);
        clear_logs();
        @(posedge clk); #1;
        req = 1'b1;
        acc_cyc = cyc;
        for (int i = 0; i < 1000 && busy_rise_q.size() < 2; i++) @(posedge clk);
        #1 req = 1'b0;
        wait_dones(2, 1000, ok);
        repeat (10) @(posedge clk);
        checks++;
        if (!ok || done_cyc_q.size() != 2 || busy_rise_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got done=%0d busy_rises=%0d want 2 2", done_cyc_q.size(), busy_rise_q.size());
        end else begin
            checks++;
            if (busy_rise_q[0] != acc_cyc + 1 || busy_rise_q[1] != done_cyc_q[0] + 1) begin
                errors++;
                $display("FAIL b2b_gap: got rise0=%0d rise1=%0d want %0d %0d", busy_rise_q[0], busy_rise_q[1], acc_cyc + 1, done_cyc_q[0] + 1);
            end
        end
        checks++;
        if (act_q.size() != 4 || act_q[2] !== exp_q[2] || act_q[3] !== exp_q[3] || act_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_writes: got n=%0d %h %h want %h %h", act_q.size(), act_q[2], act_q[3], exp_q[2], exp_q[3]);
        end
    endtask

`ifdef MMCM_RECONFIG_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        directed_cfg();
        k_lat = 1;
        lock_delay = -1;
        clear_logs();
        start_req();
        for (int i = 0; i < 500 && err_cyc_q.size() < 1; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_cyc_q.size() != 1 || err_cyc_q[0] != rst_fall_cyc + 1 + LOCK_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_time: got %0d want %0d", err_cyc_q.size() ? err_cyc_q[0] : -1, rst_fall_cyc + 1 + LOCK_TIMEOUT);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || mmcm_rst !== 1'b0 || done_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_state: got err=%b busy=%b rst=%b dones=%0d want 1 0 0 0", err, busy, mmcm_rst, done_cyc_q.size());
        end
        lock_delay = 4;
        clear_logs();
        start_req();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b busy=%b want 0 1", err, busy);
        end
        wait_dones(1, 500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_recover: got dones=%0d want 1", done_cyc_q.size());
        end
    endtask
`else
    task automatic test_timeout();
        directed_cfg();
        k_lat = 1;
        lock_delay = -1;
        clear_logs();
        start_req();
        repeat (300) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || mmcm_rst !== 1'b0 || done_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL no_timeout_wait: got busy=%b err=%b rst=%b dones=%0d want 1 0 0 0", busy, err, mmcm_rst, done_cyc_q.size());
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_rst: got busy=%b want 0", busy);
        end
        lock_delay = 0;
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (den_no_rst != 0 || dwe_alone != 0 || done_err != 0) begin
            errors++;
            $display("FAIL invariants: got den_no_rst=%0d dwe_alone=%0d done_err=%0d want 0 0 0", den_no_rst, dwe_alone, done_err);
        end
    endtask

    initial begin
        req = 1'b0;
        rst = 1'b1;
        locked = 1'b0;
        drdy = 1'b0;
        dout = 16'h0;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        directed_cfg();
        test_reset();
        test_directed();
        test_random();
        test_rst_mid();
        test_spurious();
        test_back_to_back();
        test_timeout();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
